// File: rtl/alu32_arbiter.sv
// -----------------------------------------------------------------------------
// alu32_arbiter
//
// Purpose:
//   Shares one 32-bit ALU between two requesters. A round-robin arbiter picks
//   a winner while idle, latches that requester's opcode and operands, spends
//   EXEC_CYCLES cycles executing, then publishes the result for one DONE cycle.
//
// Handshake (valid/ready style, one transaction per Req):
//   ReqN is a level "valid" that the requester holds until its DonePN pulse.
//   It is sampled only while the FSM is idle. GntN is a one-cycle "accepted"
//   pulse: OpN/AN/BN have been captured and may change freely afterwards.
//   DoneN is a one-cycle "complete" pulse; Result/Zero are valid with it and
//   hold until the next completion. Dropping ReqN after GntN does not cancel
//   the operation.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   Req0/Req1         request levels
//   Op0/Op1 [2:0]     opcodes: AND, OR, XOR, ADD, SUB, NOR, 110/111 reserved
//   A0/B0/A1/B1[31:0] operands
//   Gnt0/Gnt1         grant pulses (first EXEC cycle)
//   Done0/Done1       completion pulses (DONE cycle)
//   Result [31:0]     result of the last completed operation
//   Zero              Result == 0
//   Busy              FSM not idle
//   dbg_state [1:0]   current FSM state, for observation only
// -----------------------------------------------------------------------------
module alu32_arbiter #(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [2:0]  Op0,
  input  logic [2:0]  Op1,
  input  logic [31:0] A0,
  input  logic [31:0] B0,
  input  logic [31:0] A1,
  input  logic [31:0] B1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        Done0,
  output logic        Done1,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter is loaded with EXEC_CYCLES-1 so that zero marks the last EXEC cycle.
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;   // requester granted most recently
  logic        win_q, win_d;     // requester owning the operation in flight
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        busy_q, busy_d;
  logic [31:0] alu_out;

  // Combinational ALU on the latched operation.
  always_comb begin
    alu_out = 32'd0;
    case (op_q)
      3'b000:  alu_out = a_q & b_q;
      3'b001:  alu_out = a_q | b_q;
      3'b010:  alu_out = a_q ^ b_q;
      3'b011:  alu_out = a_q + b_q;
      3'b100:  alu_out = a_q - b_q;
      3'b101:  alu_out = ~(a_q | b_q);
      default: alu_out = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win_d    = win_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE: begin
        if (Req0 || Req1) begin
          // Requester 1 wins when it is alone, or on a tie when 0 went last.
          win_d   = Req1 && (!Req0 || !last_q);
          op_d    = win_d ? Op1 : Op0;
          a_d     = win_d ? A1  : A0;
          b_d     = win_d ? B1  : B0;
          cnt_d   = CNT_INIT;
          gnt0_d  = !win_d;
          gnt1_d  = win_d;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d = alu_out;
          zero_d   = (alu_out == 32'd0);
          done0_d  = !win_q;
          done1_d  = win_q;
          last_d   = win_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= 32'd0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
    end
  end

  assign Gnt0      = gnt0_q;
  assign Gnt1      = gnt1_q;
  assign Done0     = done0_q;
  assign Done1     = done1_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu32_arbiter.sv
module tb_alu32_arbiter;

  localparam int EC = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        Req0, Req1;
  logic [2:0]  Op0, Op1;
  logic [31:0] A0, B0, A1, B1;
  logic        Gnt0, Gnt1, Done0, Done1, Zero, Busy;
  logic [31:0] Result;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  alu32_arbiter #(.EXEC_CYCLES(EC)) dut (
    .clk(clk), .rst_n(rst_n),
    .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Result(Result), .Zero(Zero), .Busy(Busy), .dbg_state(dbg_state)
  );

  // ---------------- reference model state ----------------
  int          checks = 0;
  int          errors = 0;
  int          m_last;          // requester granted most recently
  logic [31:0] m_result;        // last published result
  logic [31:0] exp_q[$];        // expected results, oldest first
  int          win_log[$];      // winners in grant order

  function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua, ub, r;
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0:    r = ua & ub;
      3'd1:    r = ua | ub;
      3'd2:    r = ua ^ ub;
      3'd3:    r = (ua + ub) % 64'h1_0000_0000;
      3'd4:    r = (ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000;
      3'd5:    r = 64'hFFFF_FFFF - (ua | ub);
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("gnt_exclusive", {31'd0, Gnt0 & Gnt1}, 32'd0);
    chk("done_exclusive", {31'd0, Done0 & Done1}, 32'd0);
  endtask

  // ---------------- driver: one full transaction from IDLE ----------------
  task automatic do_op(input logic r0, input logic r1,
                       input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic scramble);
    int          w;
    logic [31:0] exp_res;
    logic [31:0] got;
    Req0 = r0; Req1 = r1;
    Op0 = o0; A0 = a0; B0 = b0;
    Op1 = o1; A1 = a1; B1 = b1;
    // Round-robin rule: a lone requester wins; a tie goes to whoever did not go last.
    if (r0 && r1) w = (m_last == 0) ? 1 : 0;
    else          w = r1 ? 1 : 0;
    exp_res = (w == 1) ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0);
    exp_q.push_back(exp_res);
    chk("idle_busy", {31'd0, Busy}, 32'd0);
    chk("result_hold", Result, m_result);

    tick();
    chk("gnt0", {31'd0, Gnt0}, (w == 0) ? 32'd1 : 32'd0);
    chk("gnt1", {31'd0, Gnt1}, (w == 1) ? 32'd1 : 32'd0);
    chk("exec_busy", {31'd0, Busy}, 32'd1);
    chk("result_hold_exec", Result, m_result);
    win_log.push_back(w);

    if (scramble) begin
      Op0 = 3'($urandom_range(0, 7)); A0 = $urandom; B0 = $urandom;
      Op1 = 3'($urandom_range(0, 7)); A1 = $urandom; B1 = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (w == 0) Req0 = 1'b0; else Req1 = 1'b0;
      end
    end

    for (int i = 1; i < EC; i++) begin
      tick();
      chk("exec_no_gnt", {30'd0, Gnt0, Gnt1}, 32'd0);
      chk("exec_no_done", {30'd0, Done0, Done1}, 32'd0);
    end

    tick();
    got = exp_q.pop_front();
    chk("done0", {31'd0, Done0}, (w == 0) ? 32'd1 : 32'd0);
    chk("done1", {31'd0, Done1}, (w == 1) ? 32'd1 : 32'd0);
    chk("result", Result, got);
    chk("zero", {31'd0, Zero}, (got == 32'd0) ? 32'd1 : 32'd0);
    chk("done_busy", {31'd0, Busy}, 32'd1);
    m_last   = w;
    m_result = got;
    if (w == 0) Req0 = 1'b0; else Req1 = 1'b0;

    tick();
    chk("post_done", {30'd0, Done0, Done1}, 32'd0);
    chk("post_busy", {31'd0, Busy}, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0;
    Op0 = 3'd0; Op1 = 3'd0;
    A0 = 32'd0; B0 = 32'd0; A1 = 32'd0; B1 = 32'd0;
    m_last = 1;
    m_result = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", Result, 32'd0);
    chk("rst_zero", {31'd0, Zero}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_pulses", {28'd0, Gnt0, Gnt1, Done0, Done1}, 32'd0);
    rst_n = 1'b1;

    // Both requesters held: grants must alternate starting with requester 0.
    for (int i = 0; i < 4; i++)
      do_op(1'b1, 1'b1, 3'd2, 32'hA5A5_0000 + i, 32'h0F0F_0F0F,
            3'd0, 32'hFFFF_0000, 32'h00FF_FF00 + i, 1'b0);
    for (int i = 0; i < 4; i++)
      chk("tie_order", win_log[i], 32'(i % 2));

    // OR example.
    do_op(1'b1, 1'b0, 3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("or_value", Result, 32'hF0F0_0F0F);
    // ADD wrap and SUB borrow.
    do_op(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("add_wrap", Result, 32'h0000_0000);
    chk("add_zero", {31'd0, Zero}, 32'd1);
    do_op(1'b1, 1'b0, 3'd4, 32'd0, 32'd1, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("sub_borrow", Result, 32'hFFFF_FFFF);
    chk("sub_zero", {31'd0, Zero}, 32'd0);
    // Reserved opcode.
    do_op(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 3'd7, 32'h1234_5678, 32'h1234_5678, 1'b0);
    chk("reserved_zero", {31'd0, Zero}, 32'd1);
    // Operand change after grant must not leak into the result.
    do_op(1'b1, 1'b0, 3'd3, 32'h0000_0005, 32'h0000_0003, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("latched_add", Result, 32'h0000_0008);

    // Reset during EXEC: no Done, outputs cleared at once, pointer back to 1.
    Req0 = 1'b0; Req1 = 1'b1; Op1 = 3'd3; A1 = 32'd10; B1 = 32'd20;
    tick();
    chk("pre_rst_gnt1", {31'd0, Gnt1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_result", Result, 32'd0);
    chk("midrst_zero", {31'd0, Zero}, 32'd1);
    chk("midrst_pulses", {28'd0, Gnt0, Gnt1, Done0, Done1}, 32'd0);
    repeat (2) tick();
    chk("midrst_no_done", {30'd0, Done0, Done1}, 32'd0);
    m_last = 1;
    m_result = 32'd0;
    rst_n = 1'b1;
    // Req1 still high: granted right after the first sampling edge.
    do_op(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 3'd3, 32'd10, 32'd20, 1'b0);
    // Tie after reset goes to requester 1's opponent only if 1 went last.
    do_op(1'b1, 1'b1, 3'd5, 32'h0000_00FF, 32'h0F00_0000, 3'd2, 32'd7, 32'd7, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int pat;
      pat = $urandom_range(1, 3);
      do_op(pat[0], pat[1],
            3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
            1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu32_arbiter.md
ALU32_ARBITER -- requirements
Module: alu32_arbiter

Interface
REQ-001 Parameter: EXEC_CYCLES, default 2, number of cycles spent in EXEC per operation; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: Req0, Req1  input  1 each  request from requester 0 / 1, level, held until the matching Done pulse.
REQ-005 Port: Op0, Op1  input  3 each  opcode of requester 0 / 1: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (A-B), 101 NOR, 110/111 reserved.
REQ-006 Port: A0, B0, A1, B1  input  32 each  operands of requester 0 / 1.
REQ-007 Port: Gnt0, Gnt1  output  1 each  one-cycle grant pulse; operands and opcode are latched.
REQ-008 Port: Done0, Done1  output  1 each  one-cycle completion pulse for the granted requester.
REQ-009 Port: Result  output  32  registered result of the last completed operation.
REQ-010 Port: Zero  output  1  high when Result == 0, registered together with Result.
REQ-011 Port: Busy  output  1  high in every state other than IDLE.

Function
REQ-012 FSM states: IDLE, EXEC, DONE; all outputs are registered.
REQ-013 IDLE: Req0/Req1 are sampled only in IDLE; if no request is high, the FSM stays in IDLE.
REQ-014 IDLE with at least one request: winner chosen, winner's Op/A/B latched, next state EXEC, winner's Gnt high for the first EXEC cycle only.
REQ-015 Arbitration: round-robin; with both Req high, the requester not granted last wins; with one Req high, that requester wins.
REQ-016 Last-granted pointer is updated on entry to DONE.
REQ-017 EXEC: lasts exactly EXEC_CYCLES cycles, counted by an internal down-counter.
REQ-018 Leaving EXEC: Result and Zero are loaded from the latched op, next state DONE.
REQ-019 DONE: lasts one cycle, winner's Done high, next state IDLE.
REQ-020 Latency: Req first seen high in IDLE at cycle T -> Gnt at T+1 -> Done, Result and Zero valid at T+1+EXEC_CYCLES.
REQ-021 Throughput: one operation per EXEC_CYCLES+2 cycles.
REQ-022 Arithmetic: 32-bit modulo 2^32; carry/borrow discarded; no overflow flag.
REQ-023 Reserved opcodes complete normally with Result = 0 and Zero = 1.
REQ-024 Changes on Op/A/B after Gnt do not affect the operation in flight.
REQ-025 Deasserting Req after Gnt does not abort the operation; Done is still issued.
REQ-026 Result and Zero hold their value until the next DONE entry.
REQ-027 Gnt0/Gnt1 are never high together; Done0/Done1 are never high together.

Reset
REQ-028 rst_n low, at any time including mid-EXEC: state IDLE immediately; Gnt*, Done*, Busy, Result = 0; Zero = 1; counter = 0.
REQ-029 Reset sets the last-granted pointer to requester 1, so requester 0 wins the first tie.
REQ-030 An operation interrupted by reset produces no Done.
REQ-031 The first request is sampled on the first rising edge with rst_n high.

Verification (EXEC_CYCLES=2)
REQ-032 Req0 with Op0=001, A0=0xF0F00000, B0=0x00000F0F at T -> Gnt0 at T+1, Done0 at T+3, Result=0xF0F00F0F, Zero=0.
REQ-033 Req0 and Req1 high together after reset, both held -> grant order Gnt0, Gnt1, Gnt0, ...; no two consecutive grants to the same requester.
REQ-034 ADD A=0xFFFFFFFF, B=0x00000001 -> Result=0x00000000, Zero=1; SUB A=0, B=1 -> Result=0xFFFFFFFF, Zero=0.
REQ-035 Op=111 with A=B=0x12345678 -> Done issued, Result=0, Zero=1.
REQ-036 A0 changed from 0x00000005 to 0xFFFFFFFF the cycle after Gnt0 with Op0=011, B0=0x00000003 -> Result=0x00000008.
REQ-037 rst_n pulsed low during EXEC -> no Done, Busy=0 immediately; Req1 still high after release -> Gnt1 one cycle after the first sampling edge.
